fetch_sequencer: RTL
====================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after start.
REQ-002 Parameter INST_BYTES, default 1156, size of byte-addressed instruction memory.
REQ-003 Parameter NOP_INST, default 32'h0000_0013, bubble instruction (addi x0,x0,0).
REQ-004 clock  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 start  input  1  leave IDLE and begin fetching.
REQ-007 stall  input  1  hazard-unit stall; hold PC and IF/ID contents.
REQ-008 flush  input  1  taken branch/jump resolved; redirect fetch.
REQ-009 branch_target  input  32  redirect byte address, sampled when flush=1.
REQ-010 mem_pc  output  32  byte address driven to instruction memory.
REQ-011 mem_stall  output  1  gates instruction memory (memory returns 0 when 1).
REQ-012 mem_inst  input  32  combinational read data {b[pc],b[pc+1],b[pc+2],b[pc+3]}.
REQ-013 if_pc  output  32  PC of instruction in IF/ID register.
REQ-014 if_inst  output  32  instruction in IF/ID register.
REQ-015 if_valid  output  1  if_inst is a real fetched instruction.
REQ-016 halted  output  1  sequencer in HALT.
REQ-017 error  output  1  halt caused by misaligned or out-of-range PC.
REQ-018 fetch_count  output  32  instructions accepted into IF/ID.
REQ-019 bubble_count  output  32  bubbles inserted by flush.

Function
REQ-020 States IDLE, RUN, HALT; IDLE->RUN on start; RUN->HALT on ECALL fetch, out-of-range PC, or misaligned target; HALT exits only via reset; start ignored outside IDLE.
REQ-021 mem_pc = pc register combinationally (zero latency to memory).
REQ-022 mem_stall = 1 when state != RUN or stall=1; else 0.
REQ-023 RUN, flush=0, stall=0, pc in range: next edge if_inst<=mem_inst, if_pc<=pc, if_valid<=1, pc<=pc+4, fetch_count+1.
REQ-024 RUN, stall=1, flush=0: pc, if_pc, if_inst, if_valid, counters held.
REQ-025 RUN, flush=1: pc<=branch_target, if_inst<=NOP_INST, if_valid<=0, bubble_count+1; flush wins over stall.
REQ-026 flush=1 with branch_target[1:0]!=0: ->HALT, error<=1, pc unchanged, if_inst<=NOP_INST, if_valid<=0.
REQ-027 In range means pc+3 <= INST_BYTES-1; RUN with pc out of range and no flush: ->HALT, error<=1, no fetch.
REQ-028 Fetch of 32'h0000_0073 (ECALL): instruction accepted into IF/ID as in REQ-023, then ->HALT, error stays 0, pc not advanced.
REQ-029 IDLE and HALT: if_valid=0, if_inst=NOP_INST, stall/flush ignored, counters frozen.
REQ-030 pc+4 and counters wrap modulo 2^32 (no saturation).
REQ-031 IDLE->RUN edge loads pc<=RESET_PC; first fetch occurs the following cycle.

Reset
REQ-032 reset=0 at an edge forces, regardless of state (including mid-stall/mid-flush): state IDLE, pc RESET_PC, if_pc 0, if_inst NOP_INST, if_valid 0, halted 0, error 0, counters 0.
REQ-033 Outputs derived from state (halted, mem_stall) reflect reset values in the cycle after the reset edge.

Structure
REQ-034 Shared package fetch_pkg holds state enum, NOP_INST and ECALL constants, default INST_BYTES.
REQ-035 One sub-module perf_counter (32-bit, enable, sync active-low clear), instantiated twice for fetch_count and bubble_count.

Verification
REQ-036 reset, start, 4 sequential instrs at 0,4,8,12 -> if_pc 0,4,8,12 one cycle after each mem_pc, if_valid=1, fetch_count=4.
REQ-037 stall held 3 cycles at pc=8 -> mem_pc=8, if_* unchanged, mem_stall=1, fetch_count unchanged.
REQ-038 flush+stall same cycle, target 0x40 -> next mem_pc=0x40, if_inst=0x13, if_valid=0, bubble_count=1.
REQ-039 flush target 0x42 -> halted=1, error=1, if_valid=0, counters frozen.
REQ-040 ECALL at pc=0x10 -> if_inst=0x73, if_pc=0x10, then halted=1, error=0, mem_pc stays 0x10.
REQ-041 pc reaches 1156 (INST_BYTES) -> halted=1, error=1; reset mid-RUN -> all REQ-032 values next cycle.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch sequencer slice.
package fetch_pkg;
  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_HALT = 2'd2;

  localparam logic [31:0] NOP_INST_C     = 32'h0000_0013;
  localparam logic [31:0] ECALL_INST     = 32'h0000_0073;
  localparam int          DEF_INST_BYTES = 1156;
endpackage

// File: rtl/fetch_sequencer_if.sv
// Fetch-stage bus: control in, instruction memory port, IF/ID view and status out.
interface fetch_sequencer_if;
  logic        start;
  logic        stall;
  logic        flush;
  logic [31:0] branch_target;
  logic [31:0] mem_pc;
  logic        mem_stall;
  logic [31:0] mem_inst;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;
  logic        halted;
  logic        error;
  logic [31:0] fetch_count;
  logic [31:0] bubble_count;

  modport master (
    output start, stall, flush, branch_target, mem_inst,
    input  mem_pc, mem_stall, if_pc, if_inst, if_valid, halted, error,
           fetch_count, bubble_count
  );

  modport slave (
    input  start, stall, flush, branch_target, mem_inst,
    output mem_pc, mem_stall, if_pc, if_inst, if_valid, halted, error,
           fetch_count, bubble_count
  );
endinterface

// File: rtl/fetch_sequencer_perf_counter.sv
// 32-bit event counter with enable and synchronous active-low clear; wraps modulo 2^32.
module perf_counter (
  input  logic        clock,
  input  logic        i_clr_n,
  input  logic        i_en,
  output logic [31:0] o_count
);
  logic [31:0] r_count;

  always_ff @(posedge clock) begin
    if (!i_clr_n) begin
      r_count <= 32'd0;
    end else if (i_en) begin
      r_count <= r_count + 32'd1;
    end
  end

  assign o_count = r_count;
endmodule

// File: rtl/fetch_sequencer.sv
// IF-stage sequencer: PC register, IF/ID register and IDLE/RUN/HALT control.
// Memory sees the PC with zero latency; the fetched word lands in IF/ID one edge later.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          INST_BYTES = DEF_INST_BYTES,
  parameter logic [31:0] NOP_INST   = NOP_INST_C
) (
  input logic         clock,
  input logic         reset,
  fetch_sequencer_if.slave bus
);
  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_if_pc;
  logic [31:0] r_if_inst;
  logic        r_if_valid;
  logic        r_error;

  logic w_run;
  logic w_tgt_ok;
  logic w_pc_ok;
  logic w_fetch;
  logic w_bubble;

  assign w_run    = (r_state == ST_RUN);
  assign w_tgt_ok = (bus.branch_target[1:0] == 2'b00);
  // 33-bit sum so a PC near 2^32 cannot wrap back into range
  assign w_pc_ok  = (r_pc[1:0] == 2'b00) &&
                    (({1'b0, r_pc} + 33'd3) < 33'(INST_BYTES));
  assign w_fetch  = w_run && !bus.flush && !bus.stall && w_pc_ok;
  assign w_bubble = w_run && bus.flush && w_tgt_ok;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_pc       <= RESET_PC;
      r_if_pc    <= 32'd0;
      r_if_inst  <= NOP_INST;
      r_if_valid <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_if_inst  <= NOP_INST;
          r_if_valid <= 1'b0;
          if (bus.start) begin
            r_state <= ST_RUN;
            r_pc    <= RESET_PC;
          end
        end
        ST_RUN: begin
          if (bus.flush) begin
            r_if_inst  <= NOP_INST;
            r_if_valid <= 1'b0;
            if (w_tgt_ok) begin
              r_pc <= bus.branch_target;
            end else begin
              r_state <= ST_HALT;
              r_error <= 1'b1;
            end
          end else if (!bus.stall) begin
            if (w_pc_ok) begin
              r_if_inst  <= bus.mem_inst;
              r_if_pc    <= r_pc;
              r_if_valid <= 1'b1;
              // ECALL is kept in IF/ID but the PC stays on it
              if (bus.mem_inst == ECALL_INST) begin
                r_state <= ST_HALT;
              end else begin
                r_pc <= r_pc + 32'd4;
              end
            end else begin
              r_state    <= ST_HALT;
              r_error    <= 1'b1;
              r_if_inst  <= NOP_INST;
              r_if_valid <= 1'b0;
            end
          end
        end
        default: begin
          r_if_inst  <= NOP_INST;
          r_if_valid <= 1'b0;
        end
      endcase
    end
  end

  perf_counter u_fetch_cnt (
    .clock   (clock),
    .i_clr_n (reset),
    .i_en    (w_fetch),
    .o_count (bus.fetch_count)
  );

  perf_counter u_bubble_cnt (
    .clock   (clock),
    .i_clr_n (reset),
    .i_en    (w_bubble),
    .o_count (bus.bubble_count)
  );

  assign bus.mem_pc    = r_pc;
  assign bus.mem_stall = !w_run || bus.stall;
  assign bus.if_pc     = r_if_pc;
  assign bus.if_inst   = r_if_inst;
  assign bus.if_valid  = r_if_valid;
  assign bus.halted    = (r_state == ST_HALT);
  assign bus.error     = r_error;
endmodule
